// File: rtl/lb_pkg.sv
// Shared constants and helpers for the line buffer.
package lb_pkg;

    // Default geometry: 8-bit pixels, 1080p line length, 3-row kernel.
    localparam int unsigned LB_DATA_W      = 8;
    localparam int unsigned LB_LINE_LEN    = 1920;
    localparam int unsigned LB_KERNEL_ROWS = 3;

    // Slice index of the current pixel in a column; row r sits at [r*DATA_W +: DATA_W],
    // so higher slices hold older lines.
    localparam int unsigned LB_CUR_ROW = 0;

    // Ceiling log2, usable in parameter defaults.
    function automatic int unsigned lb_clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 1) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lb_ram.sv
// Simple dual-port RAM: write port A, registered read-first port B.
module lb_ram
    import lb_pkg::*;
#(
    parameter int unsigned DATA_W = LB_DATA_W,
    parameter int unsigned DEPTH  = LB_LINE_LEN,
    parameter int unsigned ADDR_W = lb_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and read share one clock; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_buffer.sv
// Multi-line pixel buffer: for every accepted pixel emits a vertical column of
// KERNEL_ROWS pixels (current pixel in the low slice, oldest line in the high slice).
// Optional feature macro: LINE_BUFFER_REPLICATE_EN -- unfilled rows replicate the
// oldest filled row instead of reading as zero.
module line_buffer
    import lb_pkg::*;
#(
    parameter int unsigned DATA_W      = LB_DATA_W,
    parameter int unsigned LINE_LEN    = LB_LINE_LEN,
    parameter int unsigned KERNEL_ROWS = LB_KERNEL_ROWS,
    parameter int unsigned ADDR_W      = lb_clog2(LINE_LEN)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_sof,
    input  logic                          s_eol,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [KERNEL_ROWS*DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0]             m_col,
    output logic                          m_eol,
    output logic                          m_full,
    output logic                          line_err
);

    localparam int unsigned BANKS  = KERNEL_ROWS - 1;
    localparam int unsigned FILL_W = (lb_clog2(KERNEL_ROWS) > 0) ? lb_clog2(KERNEL_ROWS) : 1;
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(KERNEL_ROWS - 1);

    logic              accept;
    logic [ADDR_W-1:0] col_q, col_d, base_col;
    logic [FILL_W-1:0] fill_q, fill_d, base_fill;
    logic              wrap, overrun;

    logic              m_valid_q;
    logic [DATA_W-1:0] pix_q;
    logic [ADDR_W-1:0] m_col_q;
    logic              m_eol_q;
    logic [FILL_W-1:0] m_fill_q;
    logic              line_err_q;
    logic              wr_en_q;
    logic              fwd_q;
    logic              fwd_hit;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] bank_dout  [BANKS];
    logic [DATA_W-1:0] dout_eff   [BANKS];
    logic [DATA_W-1:0] bank_wdata [BANKS];
    logic [DATA_W-1:0] fwd_data_q [BANKS];
    logic [DATA_W-1:0] rows       [KERNEL_ROWS];

    assign s_ready  = !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready;
    assign m_valid  = m_valid_q;
    assign m_col    = m_col_q;
    assign m_eol    = m_eol_q;
    assign m_full   = (m_fill_q == FILL_MAX);
    assign line_err = line_err_q;

    // Hold the read address on the emitted column while stalled; reads fire only on accept.
    assign rd_addr = accept ? base_col : m_col_q;

    // A one-pixel line (or sof at column 0 right after column 0) reads the address that is
    // being written back this very cycle; the read-first RAM would return stale data.
    assign fwd_hit = wr_en_q && (base_col == m_col_q);

    // Position of the incoming pixel and the line/fill bookkeeping it causes.
    always_comb begin
        base_col  = s_sof ? '0 : col_q;
        base_fill = s_sof ? '0 : fill_q;
        overrun   = (base_col == LAST_COL) && !s_eol;
        wrap      = s_eol || (base_col == LAST_COL);
        col_d     = wrap ? '0 : base_col + ADDR_W'(1);
        if (wrap) begin
            fill_d = (base_fill == FILL_MAX) ? FILL_MAX : base_fill + FILL_W'(1);
        end else begin
            fill_d = base_fill;
        end
    end

    // Output stage, counters and write-back strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            fill_q     <= '0;
            m_valid_q  <= 1'b0;
            pix_q      <= '0;
            m_col_q    <= '0;
            m_eol_q    <= 1'b0;
            m_fill_q   <= '0;
            line_err_q <= 1'b0;
            wr_en_q    <= 1'b0;
            fwd_q      <= 1'b0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                m_valid_q <= 1'b1;
                pix_q     <= s_data;
                m_col_q   <= base_col;
                m_eol_q   <= s_eol;
                m_fill_q  <= base_fill;
                col_q     <= col_d;
                fill_q    <= fill_d;
                fwd_q     <= fwd_hit;
                if (overrun) begin
                    line_err_q <= 1'b1;
                end
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    // Capture the word being written back when the next read collides with it.
    always_ff @(posedge clk) begin
        if (accept && fwd_hit) begin
            for (int j = 0; j < int'(BANKS); j++) begin
                fwd_data_q[j] <= bank_wdata[j];
            end
        end
    end

    // Effective bank outputs and the cascaded write-back data.
    always_comb begin
        for (int j = 0; j < int'(BANKS); j++) begin
            dout_eff[j] = fwd_q ? fwd_data_q[j] : bank_dout[j];
        end
        bank_wdata[0] = pix_q;
        for (int j = 1; j < int'(BANKS); j++) begin
            bank_wdata[j] = dout_eff[j-1];
        end
    end

    for (genvar j = 0; j < int'(BANKS); j++) begin : g_bank
        lb_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (LINE_LEN),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_en_q),
            .wr_addr (m_col_q),
            .wr_data (bank_wdata[j]),
            .rd_en   (accept),
            .rd_addr (rd_addr),
            .rd_data (bank_dout[j])
        );
    end

    // Assemble the column and mask rows that have no real line behind them yet.
    always_comb begin
        rows[LB_CUR_ROW] = pix_q;
        for (int j = 0; j < int'(BANKS); j++) begin
            rows[j+1] = dout_eff[j];
        end
        m_data = '0;
        for (int r = 0; r < int'(KERNEL_ROWS); r++) begin
            if (r <= int'(m_fill_q)) begin
                m_data[r*DATA_W +: DATA_W] = rows[r];
            end
`ifdef LINE_BUFFER_REPLICATE_EN
            else begin
                m_data[r*DATA_W +: DATA_W] = rows[m_fill_q];
            end
`endif
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer (DATA_W=8, LINE_LEN=4, KERNEL_ROWS=3).
module tb_line_buffer;

    localparam int DW = 8;
    localparam int LL = 4;
    localparam int KR = 3;
    localparam int AW = 2;

`ifdef LINE_BUFFER_REPLICATE_EN
    localparam logic [23:0] LIT_PIX1   = 24'h010101;
    localparam logic [23:0] LIT_SOF19  = 24'h131313;
    localparam logic [23:0] LIT_SHORT  = 24'h131315;
    localparam logic [23:0] LIT_RST42  = 24'h424242;
`else
    localparam logic [23:0] LIT_PIX1   = 24'h000001;
    localparam logic [23:0] LIT_SOF19  = 24'h000013;
    localparam logic [23:0] LIT_SHORT  = 24'h001315;
    localparam logic [23:0] LIT_RST42  = 24'h000042;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [DW-1:0]    s_data = '0;
    logic             s_sof = 1'b0;
    logic             s_eol = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [KR*DW-1:0] m_data;
    logic [AW-1:0]    m_col;
    logic             m_eol;
    logic             m_full;
    logic             line_err;

    int n_checks = 0;
    int n_pass   = 0;

    line_buffer #(
        .DATA_W      (DW),
        .LINE_LEN    (LL),
        .KERNEL_ROWS (KR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .s_eol    (s_eol),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_col    (m_col),
        .m_eol    (m_eol),
        .m_full   (m_full),
        .line_err (line_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: each column keeps its own history of past lines; evaluated on the
    // falling edge, it checks the present outputs and then predicts the next rising edge.
    initial begin : model
        logic [DW-1:0] hist [LL][KR-1];
        logic [DW-1:0] rowv [KR];
        logic [KR*DW-1:0] exp_data;
        bit exp_valid, exp_eol, exp_full, err;
        int exp_col, col, fill, c, f;
        for (int i = 0; i < LL; i++)
            for (int r = 0; r < KR-1; r++) hist[i][r] = '0;
        exp_valid = 0; exp_eol = 0; exp_full = 0; err = 0;
        exp_col = 0; col = 0; fill = 0; exp_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_col", m_col, 0);
                chk("rst_m_eol", m_eol, 0);
                chk("rst_m_full", m_full, 0);
                chk("rst_line_err", line_err, 0);
                exp_valid = 0; col = 0; fill = 0; err = 0;
            end else begin
                chk("m_valid", m_valid, exp_valid);
                chk("s_ready", s_ready, !exp_valid || m_ready);
                chk("line_err", line_err, err);
                if (exp_valid) begin
                    chk("m_data", m_data, exp_data);
                    chk("m_col", m_col, exp_col);
                    chk("m_eol", m_eol, exp_eol);
                    chk("m_full", m_full, exp_full);
                end
                if (s_valid && (!exp_valid || m_ready)) begin
                    c = s_sof ? 0 : col;
                    f = s_sof ? 0 : fill;
                    rowv[0] = s_data;
                    for (int r = 1; r < KR; r++) begin
`ifdef LINE_BUFFER_REPLICATE_EN
                        rowv[r] = (r <= f) ? hist[c][r-1] : rowv[f];
`else
                        rowv[r] = (r <= f) ? hist[c][r-1] : '0;
`endif
                    end
                    for (int r = 0; r < KR; r++) exp_data[r*DW +: DW] = rowv[r];
                    for (int r = KR-2; r > 0; r--) hist[c][r] = hist[c][r-1];
                    hist[c][0] = s_data;
                    exp_valid = 1;
                    exp_col   = c;
                    exp_eol   = s_eol;
                    exp_full  = (f == KR-1);
                    if (c == LL-1 && !s_eol) err = 1;
                    if (s_eol || c == LL-1) begin
                        col  = 0;
                        fill = (f + 1 > KR-1) ? KR-1 : f + 1;
                    end else begin
                        col  = c + 1;
                        fill = f;
                    end
                end else if (m_ready) begin
                    exp_valid = 0;
                end
            end
        end
    end

    // Present one pixel (caller is just after a rising edge); returns just after the
    // rising edge that accepted it.
    task automatic push(input logic [DW-1:0] d, input logic sof, input logic eol);
        bit ok;
        ok = 0;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL push_timeout: pixel 0x%0h not accepted, got s_ready=0 required 1", d);
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    initial begin : stim
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill: three lines of 1..12 after sof.
        for (int p = 1; p <= 12; p++) begin
            push(DW'(p), p == 1, (p % 4) == 0);
            if (p == 1) begin
                chk("fill_pix1_data", m_data, LIT_PIX1);
                chk("fill_pix1_full", m_full, 0);
            end
            if (p == 4) begin
                chk("fill_pix4_col", m_col, 3);
                chk("fill_pix4_eol", m_eol, 1);
            end
            if (p == 9) begin
                chk("fill_pix9_data", m_data, 24'h010509);
                chk("fill_pix9_full", m_full, 1);
            end
        end

        // Backpressure mid-line.
        push(8'd13, 0, 0);
        chk("bp_col0", m_col, 0);
        push(8'd14, 0, 0);
        chk("bp_col1", m_col, 1);
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'd15;
        repeat (3) begin
            @(negedge clk);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_hold_col", m_col, 1);
            chk("bp_hold_data", m_data, 24'h060A0E);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        push(8'd15, 0, 0);
        chk("bp_col2", m_col, 2);
        push(8'd16, 0, 1);
        chk("bp_col3", m_col, 3);
        chk("bp_data16", m_data, 24'h080C10);

        // Mid-frame sof at line 2 column 2, then a short line.
        push(8'd17, 0, 0);
        push(8'd18, 0, 0);
        push(8'h13, 1, 0);
        chk("sof_col", m_col, 0);
        chk("sof_full", m_full, 0);
        chk("sof_data", m_data, LIT_SOF19);
        push(8'h14, 0, 1);
        chk("short_col", m_col, 1);
        chk("short_eol", m_eol, 1);
        push(8'h15, 0, 0);
        chk("short_wrap_col", m_col, 0);
        chk("short_wrap_data", m_data, LIT_SHORT);
        chk("short_line_err", line_err, 0);
        push(8'h16, 0, 0);
        push(8'h17, 0, 0);
        push(8'h18, 0, 1);
        push(8'h19, 0, 0);
        chk("refill_full", m_full, 1);
        chk("refill_data", m_data, 24'h131519);

        // Overrun: finish the line, then five pixels without eol.
        push(8'h1A, 0, 0);
        push(8'h1B, 0, 0);
        push(8'h1C, 0, 1);
        for (int p = 0; p < 5; p++) begin
            push(DW'(8'h1D + p), 0, 0);
            if (p == 2) chk("ovr_err_before", line_err, 0);
        end
        chk("ovr_col", m_col, 0);
        chk("ovr_err", line_err, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = DW'($urandom);
            s_sof   = ($urandom_range(0, 31) == 0);
            s_eol   = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_err_sticky", line_err, 1);

        // Async reset during a stall.
        push(8'hAA, 0, 0);
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hBB;
        @(negedge clk);
        chk("stall_valid", m_valid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_s_ready", s_ready, 1);
        chk("arst_line_err", line_err, 0);
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        push(8'h42, 0, 0);
        chk("post_rst_col", m_col, 0);
        chk("post_rst_full", m_full, 0);
        chk("post_rst_data", m_data, LIT_RST42);
        push(8'h43, 0, 0);
        chk("post_rst_col1", m_col, 1);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
